// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder_if
//  Purpose  : Valid/ready memory bus between an initiator (icache/dcache
//             mem_* side) and a memory responder.
//  Signals  : mem_valid  - request present, initiator holds payload stable
//             mem_addr   - byte address
//             mem_wdata  - write data
//             mem_wstrb  - byte enables, 0 = read
//             mem_ready  - one-cycle response pulse
//             mem_rdata  - read data, valid while mem_ready = 1
//             mem_error  - qualifies mem_ready: out-of-range/misaligned
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_error;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_error
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_error
  );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Memory-side responder for the valid/ready memory bus. Serves
//             one request at a time from an internal word-addressed SRAM
//             with WAIT extra wait cycles, byte-strobe writes and an error
//             flag for out-of-range or misaligned addresses.
//  Ports    : clk - clock, all state on rising edge
//             rst - asynchronous active-low reset (0 = reset)
//             bus - mem_responder_if.slave (request in, registered response)
//  Params   : DEPTH - log2 of number of 32-bit words
//             WAIT  - extra wait cycles before the response (0..255)
//             BASE  - byte address of word 0, WORDS*4 aligned
//  Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int          DEPTH = 10,
  parameter int          WAIT  = 1,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_responder_if.slave  bus
);

  localparam int          c_words = 1 << DEPTH;
  localparam logic [32:0] c_span  = 33'(1) << (DEPTH + 2);
  localparam logic [7:0]  c_wait  = 8'(WAIT);

  if (WAIT < 0 || WAIT > 255) begin : g_wait_illegal
    $error("mem_responder: WAIT must be in 0..255");
  end
  if (DEPTH < 1 || DEPTH > 30) begin : g_depth_illegal
    $error("mem_responder: DEPTH must be in 1..30");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_commit;

  logic [7:0]         r_cnt;
  logic [DEPTH-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_in_range;

  logic               r_ready;
  logic [31:0]        r_rdata;
  logic               r_error;

  logic [31:0]        r_mem [c_words];

  // Address decode of the live request. Since BASE is word aligned, the low
  // offset bits equal the low address bits and serve as the alignment test.
  logic [31:0]        w_off_in;
  logic               w_in_range_in;

  assign w_off_in      = bus.mem_addr - BASE;
  assign w_in_range_in = (bus.mem_addr >= BASE) &&
                         ({1'b0, w_off_in} < c_span) &&
                         (w_off_in[1:0] == 2'b00);

  // With WAIT=0 the commit edge is the same edge that samples the request,
  // so the commit operands come straight from the bus while in IDLE and
  // from the latched copy otherwise.
  logic               w_is_idle;
  logic [DEPTH-1:0]   w_cm_idx;
  logic [31:0]        w_cm_wdata;
  logic [3:0]         w_cm_wstrb;
  logic               w_cm_in_range;

  assign w_is_idle     = (r_state == S_IDLE);
  assign w_cm_idx      = w_is_idle ? w_off_in[DEPTH+1:2] : r_idx;
  assign w_cm_wdata    = w_is_idle ? bus.mem_wdata      : r_wdata;
  assign w_cm_wstrb    = w_is_idle ? bus.mem_wstrb      : r_wstrb;
  assign w_cm_in_range = w_is_idle ? w_in_range_in      : r_in_range;

  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_valid) begin
          if (WAIT == 0) begin
            w_next   = S_RESP;
            w_commit = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A withdrawn request is abandoned without any side effect.
        if (!bus.mem_valid) begin
          w_next = S_IDLE;
        end else if (r_cnt == 8'd1) begin
          w_next   = S_RESP;
          w_commit = 1'b1;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The SRAM array shares this block so that no write can land while reset
  // is asserted; its contents are deliberately left out of the reset branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_in_range <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= 32'd0;
      r_error    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_is_idle && bus.mem_valid) begin
        r_idx      <= w_off_in[DEPTH+1:2];
        r_wdata    <= bus.mem_wdata;
        r_wstrb    <= bus.mem_wstrb;
        r_in_range <= w_in_range_in;
        r_cnt      <= c_wait;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end

      // Response registers are only non-zero for the single RESP cycle.
      r_ready <= w_commit;
      r_error <= w_commit && !w_cm_in_range;
      r_rdata <= 32'd0;

      if (w_commit && w_cm_in_range) begin
        if (w_cm_wstrb == 4'b0000) begin
          r_rdata <= r_mem[w_cm_idx];
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (w_cm_wstrb[i]) begin
              r_mem[w_cm_idx][8*i +: 8] <= w_cm_wdata[8*i +: 8];
            end
          end
        end
      end
    end
  end

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;
  assign bus.mem_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder. Three instances
//             (WAIT = 0, 1, 3; DEPTH = 10; BASE = 0) share one stimulus
//             driver selected by 'sel'. Expected responses are queued when
//             a request is driven and compared when mem_ready appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  int          sel;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();
  mem_responder_if bus3 ();

  assign bus0.mem_valid = valid && (sel == 0);
  assign bus1.mem_valid = valid && (sel == 1);
  assign bus3.mem_valid = valid && (sel == 3);
  assign bus0.mem_addr  = addr;
  assign bus1.mem_addr  = addr;
  assign bus3.mem_addr  = addr;
  assign bus0.mem_wdata = wdata;
  assign bus1.mem_wdata = wdata;
  assign bus3.mem_wdata = wdata;
  assign bus0.mem_wstrb = wstrb;
  assign bus1.mem_wstrb = wstrb;
  assign bus3.mem_wstrb = wstrb;

  logic        w_ready;
  logic [31:0] w_rdata;
  logic        w_error;

  assign w_ready = (sel == 0) ? bus0.mem_ready : (sel == 1) ? bus1.mem_ready : bus3.mem_ready;
  assign w_rdata = (sel == 0) ? bus0.mem_rdata : (sel == 1) ? bus1.mem_rdata : bus3.mem_rdata;
  assign w_error = (sel == 0) ? bus0.mem_error : (sel == 1) ? bus1.mem_error : bus3.mem_error;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(10), .WAIT(0), .BASE(32'h0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_responder #(.DEPTH(10), .WAIT(1), .BASE(32'h0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_responder #(.DEPTH(10), .WAIT(3), .BASE(32'h0)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Compare the current response against the oldest queued expectation.
  task automatic pop_chk(input string tag, input int lat);
    exp_t e;
    chk({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " rdata"}, w_rdata, e.rdata);
      chk({tag, " error"}, {31'd0, w_error}, {31'd0, e.err});
      if (e.lat >= 0) chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    end
  endtask

  task automatic wait_resp(input string tag);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (w_ready === 1'b1) begin
        got = 1'b1;
        lat = c;
        break;
      end
    end
    chk({tag, " ready_seen"}, 32'(got), 32'd1);
    if (got) pop_chk(tag, lat);
  endtask

  task automatic req(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] er, input logic ee, input int lat);
    @(posedge clk);
    #1;
    addr  = a;
    wdata = d;
    wstrb = s;
    valid = 1'b1;
    sb.push_back('{rdata: er, err: ee, lat: lat});
    wait_resp(tag);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst   = 1'b0;
    valid = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    wstrb = 4'd0;
    sel   = 1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ready0", {31'd0, bus0.mem_ready}, 32'd0);
    chk("reset ready1", {31'd0, bus1.mem_ready}, 32'd0);
    chk("reset ready3", {31'd0, bus3.mem_ready}, 32'd0);
    chk("reset rdata1", bus1.mem_rdata, 32'd0);
    chk("reset error1", {31'd0, bus1.mem_error}, 32'd0);
    rst = 1'b1;

    // WAIT=1: full write, read back, byte strobes, boundary word
    sel = 1;
    req("w1 wr 0x10",  32'h10,   32'hDEAD_BEEF, 4'hF, 32'd0,         1'b0, 2);
    req("w1 rd 0x10",  32'h10,   32'd0,         4'h0, 32'hDEAD_BEEF, 1'b0, 2);
    req("w1 wrb 0x10", 32'h10,   32'h1122_3344, 4'b0101, 32'd0,      1'b0, 2);
    req("w1 rdb 0x10", 32'h10,   32'd0,         4'h0, 32'hDE22_BE44, 1'b0, 2);
    req("w1 wr 0x0",   32'h0,    32'hCAFE_F00D, 4'hF, 32'd0,         1'b0, 2);
    req("w1 wr 0xffc", 32'hFFC,  32'hA5A5_5A5A, 4'hF, 32'd0,         1'b0, 2);
    req("w1 rd 0xffc", 32'hFFC,  32'd0,         4'h0, 32'hA5A5_5A5A, 1'b0, 2);

    // Out of range / misaligned
    req("w1 rd 0x1000", 32'h1000, 32'd0,         4'h0, 32'd0, 1'b1, 2);
    req("w1 rd 0x12",   32'h12,   32'd0,         4'h0, 32'd0, 1'b1, 2);
    req("w1 wr 0x1000", 32'h1000, 32'h1234_5678, 4'hF, 32'd0, 1'b1, 2);
    req("w1 rd 0x0",    32'h0,    32'd0,         4'h0, 32'hCAFE_F00D, 1'b0, 2);

    // WAIT=0: back-to-back reads with valid held across both
    sel = 0;
    req("w0 wr 0x0", 32'h0, 32'h1111_0000, 4'hF, 32'd0, 1'b0, 1);
    req("w0 wr 0x4", 32'h4, 32'h2222_0004, 4'hF, 32'd0, 1'b0, 1);
    @(posedge clk);
    #1;
    addr  = 32'h0;
    wstrb = 4'h0;
    valid = 1'b1;
    sb.push_back('{rdata: 32'h1111_0000, err: 1'b0, lat: -1});
    sb.push_back('{rdata: 32'h2222_0004, err: 1'b0, lat: -1});
    @(negedge clk);
    chk("b2b c0 ready", {31'd0, w_ready}, 32'd0);
    @(negedge clk);
    chk("b2b c1 ready", {31'd0, w_ready}, 32'd1);
    pop_chk("b2b first", 0);
    @(posedge clk);
    #1;
    addr = 32'h4;
    @(negedge clk);
    chk("b2b c2 ready", {31'd0, w_ready}, 32'd0);
    @(negedge clk);
    chk("b2b c3 ready", {31'd0, w_ready}, 32'd1);
    pop_chk("b2b second", 0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    chk("b2b c4 ready", {31'd0, w_ready}, 32'd0);

    // WAIT=3: latency, abort in the second WAIT cycle
    sel = 3;
    req("w3 wr 0x20", 32'h20, 32'h0BAD_CAFE, 4'hF, 32'd0,         1'b0, 4);
    req("w3 rd 0x20", 32'h20, 32'd0,         4'h0, 32'h0BAD_CAFE, 1'b0, 4);
    @(posedge clk);
    #1;
    addr  = 32'h20;
    wdata = 32'hFFFF_FFFF;
    wstrb = 4'hF;
    valid = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (w_ready === 1'b1) seen = 1'b1;
      if (c == 1) begin
        @(posedge clk);
        #1;
        valid = 1'b0;
      end
    end
    chk("w3 abort no ready", 32'(seen), 32'd0);
    req("w3 rd after abort", 32'h20, 32'd0, 4'h0, 32'h0BAD_CAFE, 1'b0, 4);

    // Async reset in the middle of a WAIT=3 write
    @(posedge clk);
    #1;
    addr  = 32'h20;
    wdata = 32'h5555_5555;
    wstrb = 4'hF;
    valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("w3 rst ready", {31'd0, bus3.mem_ready}, 32'd0);
    chk("w3 rst rdata", bus3.mem_rdata, 32'd0);
    chk("w3 rst error", {31'd0, bus3.mem_error}, 32'd0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req("w3 rd after rst", 32'h20, 32'd0, 4'h0, 32'h0BAD_CAFE, 1'b0, 4);

    // Async reset truncating a WAIT=1 RESP pulse
    sel = 1;
    @(posedge clk);
    #1;
    addr  = 32'h10;
    wstrb = 4'h0;
    valid = 1'b1;
    sb.push_back('{rdata: 32'hDE22_BE44, err: 1'b0, lat: 2});
    wait_resp("w1 resp before rst");
    #1;
    rst = 1'b0;
    #1;
    chk("w1 rst in resp ready", {31'd0, bus1.mem_ready}, 32'd0);
    chk("w1 rst in resp rdata", bus1.mem_rdata, 32'd0);
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req("w1 rd after rst", 32'h10, 32'd0, 4'h0, 32'hDE22_BE44, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder (memory side) for the team's valid/ready memory bus. It serves one request at a time from an internal word-addressed SRAM.
- Parameterised wait states; byte-strobe writes; out-of-range/misaligned address error flag.
- Sits behind icache/dcache mem_* ports as on-chip RAM/ROM model and synthesizable scratchpad.

Parameters:
DEPTH, 10, log2 of number of 32-bit words (WORDS = 1<<DEPTH)
WAIT, 1, extra wait cycles before response (0..255)
BASE, 32'h0000_0000, byte address of word 0; must be WORDS*4 aligned

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
mem_valid  input  1  request present; initiator holds addr/wdata/wstrb stable until mem_ready
mem_ready  output  1  one-cycle response pulse
mem_addr  input  32  byte address
mem_wdata  input  32  write data
mem_wstrb  input  4  byte enables; 0 = read, nonzero = write
mem_rdata  output  32  read data, valid only while mem_ready=1
mem_error  output  1  qualifies mem_ready: request was out of range or misaligned

Behaviour:
- Reset (rst=0, async): state=IDLE, mem_ready=0, mem_rdata=0, mem_error=0, counter=0. SRAM contents not reset.
- All outputs registered; nothing combinational from mem_valid to mem_ready.
- Index = (mem_addr - BASE) >> 2. In range iff mem_addr >= BASE, mem_addr - BASE < WORDS*4, and mem_addr[1:0]==0. 32-bit subtraction with no wrap: an address below BASE is out of range.
- States IDLE, WAIT, RESP:
  - IDLE: if mem_valid, latch addr/wdata/wstrb/in-range flag and load counter=WAIT. Go to WAIT if WAIT>0, else to RESP.
  - WAIT: counter decrements each cycle; at counter==1, go to RESP. If mem_valid=0 in any WAIT cycle, abort to IDLE: no write, no ready.
  - Edge into RESP (commit point):
    - in-range write: for each i with wstrb[i]=1, mem[idx][8i+7:8i] <= wdata byte i; other bytes unchanged.
    - in-range read: mem_rdata <= mem[idx].
    - out of range: no write, mem_rdata <= 0, mem_error <= 1.
    - write: mem_rdata <= 0.
  - RESP: mem_ready=1 for exactly one cycle. Next edge: mem_ready, mem_rdata, mem_error all return to 0; state=IDLE.
- Latency: mem_ready is high in cycle WAIT+1 after the first cycle mem_valid is sampled high in IDLE. WAIT=0 gives ready the cycle after valid.
- Back-to-back: IDLE samples mem_valid the cycle after RESP. Minimum request spacing is WAIT+2 cycles. An initiator that drops valid on the ready edge sees no duplicate response.
- mem_valid low in RESP is ignored: the response still completes.
- Address or data changing mid-request is ignored, since latched values are used.
- Async reset during WAIT cancels the request, so no write occurs. Reset in RESP truncates the ready pulse; the write has already committed.
- Counter is 8 bits; WAIT>255 is illegal (elaboration-time check).

Test Plan:
- WAIT=1, BASE=0: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF -> ready 2 cycles after valid, error=0, rdata=0. Read 0x10 -> rdata 0xDEADBEEF.
- Byte strobes: prior word 0xDEADBEEF, write 0x11223344 with wstrb 4'b0101 -> subsequent read returns 0xDE22BE44.
- Out of range: DEPTH=10, read 0x1000 and misaligned read 0x12 -> ready with error=1, rdata=0. Write to 0x1000 leaves mem[0] unchanged (read 0x0 returns prior value).
- WAIT=0: back-to-back reads of 0x0 and 0x4, valid held across -> ready pulses exactly every 2 cycles, correct data each, never two consecutive ready cycles.
- WAIT=3: drop valid in 2nd WAIT cycle during write to 0x20 -> no ready. Later read of 0x20 returns old value.
- Assert rst=0 asynchronously mid-WAIT of a write -> mem_ready/mem_rdata/mem_error go 0 without a clock edge. Write not committed; next request after rst=1 is served normally.
